// File: rtl/pulse_sync_arb.sv
// -----------------------------------------------------------------------------
// pulse_sync_arb
//
// Destination-side pulse synchronizer for pCH toggle-encoded event lines,
// with a per-channel pending-event store and round-robin delivery of the
// pending events on a valid/ready port.
//
// Each channel:
//   async_lvl[i] -> pSTAGES-deep synchronizer -> toggle detect -> evt_pls[i]
//   evt_pls[i]   -> pending store (counter or single bit) -> round-robin pick
//
// Optional feature macro: PLS_SYNC_ARB_PEND_CNT_EN
//   defined   : pending store is an unsigned pCNT_W-bit saturating counter
//   undefined : pending store is a single bit and pCNT_W is ignored
//
// Ports
//   clk        in   1            destination clock
//   rst_n      in   1            asynchronous, active-low reset
//   async_lvl  in   pCH          toggle-encoded event lines (foreign domains)
//   evt_pls    out  pCH          one-cycle pulse per detected toggle
//   evt_valid  out  1            event presented on evt_id
//   evt_ready  in   1            consumer accepts the presented event
//   evt_id     out  clog2(pCH)   channel of the presented event
//   ovf        out  pCH          sticky per-channel overflow (event dropped)
//   ovf_clr    in   pCH          synchronous per-bit clear of ovf
// -----------------------------------------------------------------------------
module pulse_sync_arb #(
    parameter int pCH     = 4,
    parameter int pSTAGES = 2,
    parameter int pCNT_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [pCH-1:0]          async_lvl,
    output logic [pCH-1:0]          evt_pls,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [$clog2(pCH)-1:0]  evt_id,
    output logic [pCH-1:0]          ovf,
    input  logic [pCH-1:0]          ovf_clr
);

    localparam int ID_W = $clog2(pCH);

`ifdef PLS_SYNC_ARB_PEND_CNT_EN
    localparam int CNT_W = pCNT_W;
`else
    // Single pending bit per channel; the counter width is not used.
    localparam int CNT_W = 1;
    localparam int unused_cnt_w = pCNT_W;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Warm-up lasts pSTAGES+1 cycles: long enough for a line that is
    // already high at reset release to propagate through the chain and
    // into q_d without being seen as a toggle.
    localparam int WARM   = pSTAGES + 1;
    localparam int WARM_W = $clog2(WARM + 1);

    // -------------------------------------------------------------------------
    // Synchronizer chain and toggle detection
    // -------------------------------------------------------------------------
    logic [pCH-1:0]    sync_q [pSTAGES];
    logic [pCH-1:0]    sync_last;
    logic [pCH-1:0]    sync_last_d;
    logic [WARM_W-1:0] warm_cnt;
    logic              armed;

    assign sync_last = sync_q[pSTAGES-1];
    assign armed     = (warm_cnt == WARM_W'(WARM));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the chain is a handful of flops, not a RAM, so every
            // element is reset; that keeps the first edge detect well defined.
            for (int s = 0; s < pSTAGES; s++) begin
                sync_q[s] <= '0;
            end
            sync_last_d <= '0;
            warm_cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the
            // previous stage's old value, which is what forms a real chain.
            sync_q[0] <= async_lvl;
            for (int s = 1; s < pSTAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            // q_d tracks the last stage unconditionally; during warm-up this
            // absorbs any static level without producing a pulse.
            sync_last_d <= sync_last;
            if (!armed) begin
                warm_cnt <= warm_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        evt_pls = armed ? (sync_last ^ sync_last_d) : '0;
    end

    // -------------------------------------------------------------------------
    // Round-robin selection among channels with pending events
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] pend_cnt [pCH];
    logic [pCH-1:0]   has_pend;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  sel_id;
    logic             sel_found;
    logic             load_slot;
    logic             load;
    logic [pCH-1:0]   grant;
    logic [pCH-1:0]   ovf_set;

    always_comb begin
        for (int i = 0; i < pCH; i++) begin
            has_pend[i] = (pend_cnt[i] != '0);
        end
    end

    // Search starts at the channel just after the last granted one, so the
    // last winner has lowest priority on the next pick.
    always_comb begin
        int idx;
        // NOTE: every variable written here gets a default first, so no
        // path through the loop can leave one unassigned and infer a latch.
        idx       = 0;
        sel_found = 1'b0;
        sel_id    = '0;
        for (int k = 1; k <= pCH; k++) begin
            idx = (int'(rr_ptr) + k) % pCH;
            if (!sel_found && has_pend[idx]) begin
                sel_found = 1'b1;
                sel_id    = ID_W'(idx);
            end
        end
    end

    // The output register may take a new event when it is empty or its
    // current event is being handed off this cycle.
    assign load_slot = !evt_valid || evt_ready;
    assign load      = load_slot && sel_found;

    always_comb begin
        for (int i = 0; i < pCH; i++) begin
            grant[i]   = load && (sel_id == ID_W'(i));
            // A pulse is dropped only when the store is full and the same
            // cycle's grant does not free a slot.
            ovf_set[i] = evt_pls[i] && !grant[i] && (pend_cnt[i] == CNT_MAX);
        end
    end

    // -------------------------------------------------------------------------
    // Pending store and sticky overflow
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < pCH; i++) begin
                pend_cnt[i] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int i = 0; i < pCH; i++) begin
                unique case ({evt_pls[i], grant[i]})
                    2'b10: begin
                        if (pend_cnt[i] != CNT_MAX) begin
                            pend_cnt[i] <= pend_cnt[i] + 1'b1;
                        end
                    end
                    2'b01:   pend_cnt[i] <= pend_cnt[i] - 1'b1;
                    default: pend_cnt[i] <= pend_cnt[i];
                endcase
            end
            // A set in the same cycle as a clear wins.
            ovf <= (ovf & ~ovf_clr) | ovf_set;
        end
    end

    // -------------------------------------------------------------------------
    // Output register {evt_valid, evt_id} and round-robin pointer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_id    <= '0;
            rr_ptr    <= ID_W'(pCH - 1);
        end else if (load_slot) begin
            // Only reached when empty or on a handshake, so a held event is
            // never replaced and evt_valid never drops unaccepted.
            evt_valid <= sel_found;
            if (sel_found) begin
                evt_id <= sel_id;
                rr_ptr <= sel_id;
            end
        end
    end

endmodule

// File: tb/tb_pulse_sync_arb.sv
// -----------------------------------------------------------------------------
// tb_pulse_sync_arb
//
// Directed bench for pulse_sync_arb (pCH=4, pSTAGES=2, pCNT_W=4). Expected
// event ids are queued as toggles are driven and compared in order as the
// consumer accepts events. Timing-critical points are checked directly
// against the edge numbering of the toggle-to-valid path.
// -----------------------------------------------------------------------------
module tb_pulse_sync_arb;

    localparam int CH     = 4;
    localparam int STAGES = 2;
    localparam int CNT_W  = 4;

`ifdef PLS_SYNC_ARB_PEND_CNT_EN
    localparam int MAXP = (1 << CNT_W) - 1;
`else
    localparam int MAXP = 1;
`endif

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] async_lvl;
    logic [CH-1:0] evt_pls;
    logic          evt_valid;
    logic          evt_ready;
    logic [1:0]    evt_id;
    logic [CH-1:0] ovf;
    logic [CH-1:0] ovf_clr;

    int checks    = 0;
    int errors    = 0;
    int delivered = 0;
    int exp_q[$];

    pulse_sync_arb #(
        .pCH    (CH),
        .pSTAGES(STAGES),
        .pCNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_lvl(async_lvl),
        .evt_pls  (evt_pls),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_id   (evt_id),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Wait for the scoreboard to empty, bounded.
    task automatic drain(input string tag);
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) tick();
        ticks(4);
        check(tag, exp_q.size(), 0);
    endtask

    // Scoreboard: a handshake seen here completes on the following edge.
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            delivered++;
            if (exp_q.size() == 0) begin
                check("evt_unexpected", {30'b0, evt_id}, 32'hFFFF_FFFF);
            end else begin
                check("evt_id_order", {30'b0, evt_id}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;

        rst_n     = 1'b0;
        async_lvl = 4'b1010;
        evt_ready = 1'b0;
        ovf_clr   = '0;

        // ---- reset values ----
        #3;
        check("rst_evt_pls",   evt_pls,   0);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_evt_id",    evt_id,    0);
        check("rst_ovf",       ovf,       0);
        ticks(3);
        rst_n = 1'b1;

        // ---- static lines at reset release give no event ----
        for (int i = 0; i < 20; i++) begin
            tick();
            check("warm_pls",   evt_pls,   0);
            check("warm_valid", evt_valid, 0);
        end

        // ---- all four channels at once: ids 0,1,2,3 back to back ----
        evt_ready = 1'b1;
        async_lvl = async_lvl ^ 4'hF;
        for (int k = 0; k < 4; k++) exp_q.push_back(k);
        tick();                                   // edge 0
        tick();                                   // edge 1
        check("all_pls", evt_pls, 4'hF);
        ticks(2);                                 // edge 3
        for (int k = 0; k < 4; k++) begin
            check("all_valid", evt_valid, 1);
            check("all_id",    evt_id,    k);
            tick();
        end
        check("all_valid_end", evt_valid, 0);
        ticks(3);

        // ---- channels 1 and 3: order continues from the pointer ----
        async_lvl = async_lvl ^ 4'b1010;
        exp_q.push_back(1);
        exp_q.push_back(3);
        ticks(4);                                 // edge 3
        check("pair_id0", evt_id, 1);
        tick();
        check("pair_id1", evt_id, 3);
        check("pair_valid1", evt_valid, 1);
        tick();
        check("pair_valid_end", evt_valid, 0);
        ticks(3);

        // ---- single toggle on channel 2: latency and pulse width ----
        async_lvl[2] = ~async_lvl[2];
        exp_q.push_back(2);
        tick();                                   // edge 0
        check("one_pls_e0",   evt_pls,   0);
        check("one_valid_e0", evt_valid, 0);
        tick();                                   // edge 1
        check("one_pls_e1",   evt_pls,   4'b0100);
        tick();                                   // edge 2
        check("one_pls_e2",   evt_pls,   0);
        check("one_valid_e2", evt_valid, 0);
        tick();                                   // edge 3
        check("one_valid_e3", evt_valid, 1);
        check("one_id_e3",    evt_id,    2);
        tick();                                   // edge 4
        check("one_valid_e4", evt_valid, 0);
        drain("one_drain");

        // ---- channel 0 toggled 20 times with the consumer stalled ----
        // One event sits in the output register, MAXP more in the store.
        evt_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            async_lvl[0] = ~async_lvl[0];
            if (i <= MAXP) exp_q.push_back(0);
            ticks(2);
        end
        ticks(4);
        check("sat_ovf0",  ovf[0],    1);
        check("sat_valid", evt_valid, 1);
        check("sat_id",    evt_id,    0);
        d0 = delivered;
        evt_ready = 1'b1;
        drain("sat_drain");
        check("sat_count", delivered - d0, MAXP + 1);
        check("sat_ovf_sticky", ovf[0], 1);
        ovf_clr[0] = 1'b1;
        tick();
        ovf_clr[0] = 1'b0;
        check("sat_ovf_clr", ovf[0], 0);

        // ---- channel 1 toggled three times with the consumer stalled ----
        evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            async_lvl[1] = ~async_lvl[1];
            if (i <= MAXP) exp_q.push_back(1);
            ticks(2);
        end
        ticks(4);
        check("three_ovf1", ovf[1], (3 > MAXP + 1) ? 1 : 0);
        d0 = delivered;
        evt_ready = 1'b1;
        drain("three_drain");
        check("three_count", delivered - d0, (3 > MAXP + 1) ? MAXP + 1 : 3);
        ticks(2);

        // ---- stalled event stays stable, then reset mid-hold ----
        evt_ready = 1'b0;
        async_lvl[3] = ~async_lvl[3];
        exp_q.push_back(3);
        for (int n = 0; n < 10 && !evt_valid; n++) tick();
        check("hold_valid_rise", evt_valid, 1);
        async_lvl[2] = ~async_lvl[2];             // left pending behind ch 3
        exp_q.push_back(2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", evt_valid, 1);
            check("hold_id",    evt_id,    3);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", evt_valid, 0);
        check("midrst_id",    evt_id,    0);
        check("midrst_ovf",   ovf,       0);
        check("midrst_pls",   evt_pls,   0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;

        // Nothing pending survives reset; static lines stay quiet.
        d0 = delivered;
        evt_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("post_rst_pls", evt_pls, 0);
        end
        check("post_rst_none", delivered - d0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
